// File: rtl/vco_adc_ctrl.sv
// Conversion controller for a VCO-based ADC: sequences filter enable, settling
// discard and sample capture into a first-word-fall-through result FIFO.
module vco_adc_ctrl #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned SETTLE_COUNT = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start_in,
    input  logic                          abort_in,
    input  logic [9:0]                    oversample_cfg_in,
    input  logic [15:0]                   num_samples_in,
    output logic                          enable_out,
    output logic [9:0]                    oversample_out,
    input  logic [DATA_WIDTH-1:0]         data_in,
    input  logic                          data_valid_in,
    output logic [DATA_WIDTH-1:0]         rd_data_out,
    output logic                          rd_valid_out,
    input  logic                          rd_ready_in,
    output logic [$clog2(FIFO_DEPTH):0]   level_out,
    output logic                          busy_out,
    output logic                          done_out,
    output logic                          overflow_out,
    output logic                          cfg_err_out
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned SW = $clog2(SETTLE_COUNT + 1);
    localparam logic [LW-1:0] DEPTH_L     = LW'(FIFO_DEPTH);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_COUNT - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        RUN,
        DONE
    } state_t;

    state_t state, next_state;

    logic [9:0]            ratio_q;
    logic [15:0]           num_q;
    logic [15:0]           sample_cnt;
    logic [15:0]           sample_cnt_nxt;
    logic [SW-1:0]         settle_cnt;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [LW-1:0]         level_q;

    logic accept_start;
    logic cfg_reject;
    logic settle_inc;
    logic run_sample;
    logic fifo_full;
    logic pop;
    logic push;
    logic drop;

    assign sample_cnt_nxt = sample_cnt + 16'd1;
    assign fifo_full      = (level_q == DEPTH_L);
    assign rd_valid_out   = (level_q != '0);
    assign pop            = rd_valid_out && rd_ready_in;
    // A full FIFO still takes a sample when the head leaves on the same edge.
    assign push           = run_sample && (!fifo_full || pop);
    assign drop           = run_sample && fifo_full && !pop;

    assign oversample_out = ratio_q;
    assign level_out      = level_q;
    assign rd_data_out    = rd_valid_out ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state   = state;
        accept_start = 1'b0;
        cfg_reject   = 1'b0;
        settle_inc   = 1'b0;
        run_sample   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_in) begin
                    if (oversample_cfg_in != '0) begin
                        accept_start = 1'b1;
                        next_state   = SETTLE;
                    end else begin
                        cfg_reject = 1'b1;
                    end
                end
            end
            SETTLE: begin
                if (abort_in) begin
                    next_state = IDLE;
                end else if (data_valid_in) begin
                    settle_inc = 1'b1;
                    if (settle_cnt == SETTLE_LAST) begin
                        next_state = RUN;
                    end
                end
            end
            RUN: begin
                if (abort_in) begin
                    next_state = IDLE;
                end else if (data_valid_in) begin
                    run_sample = 1'b1;
                    if ((num_q != '0) && (sample_cnt_nxt == num_q)) begin
                        next_state = DONE;
                    end
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_comb begin
        enable_out = 1'b0;
        busy_out   = 1'b1;
        done_out   = 1'b0;
        unique case (state)
            IDLE:        busy_out   = 1'b0;
            SETTLE, RUN: enable_out = 1'b1;
            DONE:        done_out   = 1'b1;
            default:     busy_out   = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ratio_q      <= '0;
            num_q        <= '0;
            sample_cnt   <= '0;
            settle_cnt   <= '0;
            overflow_out <= 1'b0;
            cfg_err_out  <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level_q      <= '0;
        end else begin
            cfg_err_out <= cfg_reject;
            // Flush on an accepted start wins over any same-cycle pop.
            if (accept_start) begin
                ratio_q      <= oversample_cfg_in;
                num_q        <= num_samples_in;
                sample_cnt   <= '0;
                settle_cnt   <= '0;
                overflow_out <= 1'b0;
                wr_ptr       <= '0;
                rd_ptr       <= '0;
                level_q      <= '0;
            end else begin
                if (settle_inc) begin
                    settle_cnt <= settle_cnt + 1'b1;
                end
                if (run_sample) begin
                    sample_cnt <= sample_cnt_nxt;
                end
                if (drop) begin
                    overflow_out <= 1'b1;
                end
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if (push && !pop) begin
                    level_q <= level_q + 1'b1;
                end else if (pop && !push) begin
                    level_q <= level_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

endmodule

// File: tb/tb_vco_adc_ctrl.sv
// Bench for vco_adc_ctrl: directed scenarios followed by random traffic, all
// checked every cycle against a conversion-level reference model.
module tb_vco_adc_ctrl;

    localparam int unsigned DW     = 32;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned SETTLE = 2;

    logic          clk;
    logic          rst;
    logic          start_in;
    logic          abort_in;
    logic [9:0]    oversample_cfg_in;
    logic [15:0]   num_samples_in;
    logic          enable_out;
    logic [9:0]    oversample_out;
    logic [DW-1:0] data_in;
    logic          data_valid_in;
    logic [DW-1:0] rd_data_out;
    logic          rd_valid_out;
    logic          rd_ready_in;
    logic [2:0]    level_out;
    logic          busy_out;
    logic          done_out;
    logic          overflow_out;
    logic          cfg_err_out;

    vco_adc_ctrl #(
        .DATA_WIDTH  (DW),
        .FIFO_DEPTH  (DEPTH),
        .SETTLE_COUNT(SETTLE)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start_in         (start_in),
        .abort_in         (abort_in),
        .oversample_cfg_in(oversample_cfg_in),
        .num_samples_in   (num_samples_in),
        .enable_out       (enable_out),
        .oversample_out   (oversample_out),
        .data_in          (data_in),
        .data_valid_in    (data_valid_in),
        .rd_data_out      (rd_data_out),
        .rd_valid_out     (rd_valid_out),
        .rd_ready_in      (rd_ready_in),
        .level_out        (level_out),
        .busy_out         (busy_out),
        .done_out         (done_out),
        .overflow_out     (overflow_out),
        .cfg_err_out      (cfg_err_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned errors = 0;
    int unsigned checks = 0;

    // Reference model: a conversion is "active" from an accepted start until
    // abort or its last sample; valids_m counts filter strobes since the start.
    logic [DW-1:0] q[$];
    logic [9:0]    ratio_m  = '0;
    int            num_m    = 0;
    int            valids_m = 0;
    logic          active_m = 1'b0;
    logic          done_m   = 1'b0;
    logic          ovf_m    = 1'b0;
    logic          err_m    = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic a, input logic [9:0] cfg,
                        input logic [15:0] num, input logic v, input logic [DW-1:0] d,
                        input logic rdy);
        logic pop;
        logic push_ok;
        int   run_idx;
        rst               = r;
        start_in          = s;
        abort_in          = a;
        oversample_cfg_in = cfg;
        num_samples_in    = num;
        data_valid_in     = v;
        data_in           = d;
        rd_ready_in       = rdy;
        @(posedge clk);
        err_m = 1'b0;
        pop   = (q.size() > 0) && rdy;
        if (r) begin
            q.delete();
            ovf_m    = 1'b0;
            ratio_m  = '0;
            active_m = 1'b0;
            done_m   = 1'b0;
        end else begin
            if (done_m) begin
                done_m = 1'b0;
            end else if (!active_m) begin
                if (s && cfg != 0) begin
                    ratio_m  = cfg;
                    num_m    = int'(num);
                    q.delete();
                    pop      = 1'b0;
                    ovf_m    = 1'b0;
                    active_m = 1'b1;
                    valids_m = 0;
                end else if (s) begin
                    err_m = 1'b1;
                end
            end else if (a) begin
                active_m = 1'b0;
            end else if (v) begin
                if (valids_m >= int'(SETTLE)) begin
                    run_idx = valids_m - int'(SETTLE);
                    push_ok = (q.size() < int'(DEPTH)) || pop;
                    if (pop) begin
                        void'(q.pop_front());
                        pop = 1'b0;
                    end
                    if (push_ok) q.push_back(d);
                    else ovf_m = 1'b1;
                    if (num_m != 0 && ((run_idx + 1) % 65536) == num_m) begin
                        active_m = 1'b0;
                        done_m   = 1'b1;
                    end
                end
                valids_m++;
            end
            if (pop) void'(q.pop_front());
        end
        #1;
        chk("busy",     64'(busy_out),       64'(active_m || done_m));
        chk("enable",   64'(enable_out),     64'(active_m));
        chk("done",     64'(done_out),       64'(done_m));
        chk("cfg_err",  64'(cfg_err_out),    64'(err_m));
        chk("overflow", 64'(overflow_out),   64'(ovf_m));
        chk("ratio",    64'(oversample_out), 64'(ratio_m));
        chk("level",    64'(level_out),      64'(q.size()));
        chk("rd_valid", 64'(rd_valid_out),   64'(q.size() > 0));
        chk("rd_data",  64'(rd_data_out),    64'(q.size() > 0 ? q[0] : '0));
    endtask

    task automatic nop(input logic rdy);
        step(1'b0, 1'b0, 1'b0, 10'd0, 16'd0, 1'b0, '0, rdy);
    endtask

    task automatic go(input logic [9:0] cfg, input logic [15:0] num);
        step(1'b0, 1'b1, 1'b0, cfg, num, 1'b0, '0, 1'b0);
    endtask

    task automatic smp(input logic [DW-1:0] d, input logic rdy);
        step(1'b0, 1'b0, 1'b0, 10'd0, 16'd0, 1'b1, d, rdy);
    endtask

    initial begin
        logic       r_rst, r_start, r_abort, r_valid, r_ready;
        logic [9:0] r_cfg;

        // Reset state
        step(1'b1, 1'b1, 1'b1, 10'd5, 16'd1, 1'b1, 32'h55, 1'b1);
        step(1'b1, 1'b0, 1'b0, 10'd0, 16'd0, 1'b0, '0, 1'b0);
        chk("reset_busy", 64'(busy_out), 64'd0);
        nop(1'b0);

        // Basic finite conversion: two settle discards, three kept samples
        go(10'd64, 16'd3);
        chk("start_ratio", 64'(oversample_out), 64'd64);
        for (int i = 0; i < 5; i++) smp(32'hA + 32'(i), 1'b0);
        chk("conv_done", 64'(done_out), 64'd1);
        chk("conv_enable_off", 64'(enable_out), 64'd0);
        chk("conv_level", 64'(level_out), 64'd3);
        chk("conv_head", 64'(rd_data_out), 64'hC);
        nop(1'b0);
        for (int i = 0; i < 4; i++) nop(1'b1);

        // Zero ratio rejected
        go(10'd0, 16'd4);
        chk("cfg_err_pulse", 64'(cfg_err_out), 64'd1);
        nop(1'b0);
        chk("cfg_err_clear", 64'(cfg_err_out), 64'd0);

        // Continuous mode overflow, simultaneous push/pop while full, start ignored
        go(10'd8, 16'd0);
        smp(32'h100, 1'b0);
        smp(32'h101, 1'b0);
        for (int i = 0; i < 6; i++) smp(32'h200 + 32'(i), 1'b0);
        chk("ovf_level", 64'(level_out), 64'd4);
        chk("ovf_flag", 64'(overflow_out), 64'd1);
        chk("ovf_head", 64'(rd_data_out), 64'h200);
        step(1'b0, 1'b1, 1'b0, 10'd3, 16'd2, 1'b0, '0, 1'b0);
        smp(32'h300, 1'b1);
        chk("full_pushpop_level", 64'(level_out), 64'd4);
        step(1'b0, 1'b0, 1'b1, 10'd0, 16'd0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 5; i++) nop(1'b1);

        // Abort mid-run with a same-cycle sample
        go(10'd12, 16'd10);
        smp(32'h1, 1'b0);
        smp(32'h2, 1'b0);
        smp(32'h11, 1'b0);
        smp(32'h22, 1'b0);
        step(1'b0, 1'b0, 1'b1, 10'd0, 16'd0, 1'b1, 32'h33, 1'b0);
        chk("abort_idle", 64'(busy_out), 64'd0);
        chk("abort_level", 64'(level_out), 64'd2);
        step(1'b0, 1'b0, 1'b1, 10'd0, 16'd0, 1'b0, '0, 1'b0);

        // Start with pending data and a pop in the same cycle: flush wins
        step(1'b0, 1'b1, 1'b1, 10'd9, 16'd2, 1'b0, '0, 1'b1);
        chk("flush_level", 64'(level_out), 64'd0);
        smp(32'h5, 1'b0);
        smp(32'h6, 1'b0);
        smp(32'h44, 1'b0);

        // Reset mid-run
        step(1'b1, 1'b0, 1'b0, 10'd0, 16'd0, 1'b1, 32'h77, 1'b1);
        chk("rst_mid_level", 64'(level_out), 64'd0);
        chk("rst_mid_ratio", 64'(oversample_out), 64'd0);
        nop(1'b0);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            r_rst   = ($urandom_range(0, 99) == 0);
            r_start = ($urandom_range(0, 7) == 0);
            r_abort = ($urandom_range(0, 39) == 0);
            r_cfg   = ($urandom_range(0, 4) == 0) ? 10'd0 : 10'($urandom_range(1, 1023));
            r_valid = ($urandom_range(0, 1) == 0);
            r_ready = ($urandom_range(0, 2) == 0);
            step(r_rst, r_start, r_abort, r_cfg, 16'($urandom_range(0, 6)), r_valid,
                 32'($urandom), r_ready);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
